// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the serial add/subtract sequencer.
//   ADDSUB_WIDTH   default operand/result width
//   ADDSUB_OP_ADD  opcode byte selecting a + b
//   ADDSUB_OP_SUB  opcode byte selecting a - b
//   state_e        sequencer FSM encoding
package addsub_pkg;

    localparam int         ADDSUB_WIDTH  = 8;
    localparam logic [7:0] ADDSUB_OP_ADD = 8'h00;
    localparam logic [7:0] ADDSUB_OP_SUB = 8'h01;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4
    } state_e;

endpackage

// File: rtl/add_full.sv
// Add_full: single-bit full adder cell, the shared bit-slice of the
// serial datapath.
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out
module Add_full (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/addsub_serial_sequencer.sv
// addsub_serial_sequencer: byte-stream command controller for a bit-serial
// add/subtract. Takes opcode, A, B over a valid/ready input, computes one
// bit per cycle through a single Add_full, and presents the result over a
// valid/ready output.
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   input byte handshake, in_data = opcode or operand
//   out_valid/out_ready result handshake
//   out_data            result mod 2^WIDTH
//   out_carry           add: carry-out, sub: no-borrow (a >= b unsigned)
//   op_err              one-cycle pulse when an unknown opcode is dropped
//   out_ovf             signed overflow (only with ADDSUB_OVF_EN defined)
// Optional feature macro: ADDSUB_OVF_EN.
module addsub_serial_sequencer
    import addsub_pkg::*;
#(
    parameter int               WIDTH  = ADDSUB_WIDTH,
    parameter logic [WIDTH-1:0] OP_ADD = WIDTH'(ADDSUB_OP_ADD),
    parameter logic [WIDTH-1:0] OP_SUB = WIDTH'(ADDSUB_OP_SUB)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
`ifdef ADDSUB_OVF_EN
    output logic             out_ovf,
`endif
    output logic             op_err
);

    localparam int CW = $clog2(WIDTH);

    state_e           state;
    logic             op_sub;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
`ifdef ADDSUB_OVF_EN
    logic             msb_cin;
`endif

    logic fa_s, fa_co;
    logic xfer, last_bit;

    assign in_ready = (state == S_OP) || (state == S_A) || (state == S_B);
    assign xfer     = in_valid && in_ready;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Subtract = a + ~b + 1: b is inverted here and carry is preset to 1
    // when B is latched.
    Add_full u_fa (
        .a  (a_reg[cnt]),
        .b  (b_reg[cnt] ^ op_sub),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_OP;
            op_sub    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            op_err    <= 1'b0;
`ifdef ADDSUB_OVF_EN
            msb_cin   <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else begin
            op_err <= 1'b0;
            case (state)
                S_OP: if (xfer) begin
                    if (in_data == OP_ADD || in_data == OP_SUB) begin
                        op_sub <= (in_data == OP_SUB);
                        state  <= S_A;
                    end else begin
                        op_err <= 1'b1;
                    end
                end
                S_A: if (xfer) begin
                    a_reg <= in_data;
                    state <= S_B;
                end
                S_B: if (xfer) begin
                    b_reg <= in_data;
                    carry <= op_sub;
                    cnt   <= '0;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res[cnt] <= fa_s;
                    carry    <= fa_co;
                    cnt      <= cnt + CW'(1);
`ifdef ADDSUB_OVF_EN
                    if (last_bit) msb_cin <= carry;
`endif
                    if (last_bit) state <= S_OUT;
                end
                S_OUT: begin
                    // First cycle in S_OUT publishes the result; the output
                    // registers then hold until the consumer takes it.
                    if (!out_valid) begin
                        out_data  <= res;
                        out_carry <= carry;
`ifdef ADDSUB_OVF_EN
                        out_ovf   <= msb_cin ^ carry;
`endif
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_OP;
                    end
                end
                default: state <= S_OP;
            endcase
        end
    end

endmodule
